// File: rtl/gemm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gemm_pkg: shared sizing helpers and state types for the C-tile drain. Rev 1.0
// ---------------------------------------------------------------------------
package gemm_pkg;

  function automatic int unsigned tile_width(input int unsigned rows,
                                             input int unsigned cols,
                                             input int unsigned elem_w);
    return rows * cols * elem_w;
  endfunction

  function automatic int unsigned beats_per_tile(input int unsigned tile_w,
                                                 input int unsigned beat_w);
    return tile_w / beat_w;
  endfunction

  // Never returns 0 so single-entry/single-beat configurations still get a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned c_def_beats = beats_per_tile(tile_width(4, 16, 32), 128);

  typedef logic [idx_width(c_def_beats)-1:0] beat_idx_t;

  typedef enum logic {DrainIdle, DrainStream} drain_state_e;
  typedef enum logic {DoneNone, DonePending} done_state_e;

endpackage
`default_nettype wire

// File: rtl/gemm_tile_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gemm_tile_fifo: Depth-entry synchronous FIFO; a push is accepted when full
// if the head is popped in the same cycle. Rev 1.0
// ---------------------------------------------------------------------------
module gemm_tile_fifo
  import gemm_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned c_ptr_w = idx_width(Depth);
  localparam int unsigned c_cnt_w = $clog2(Depth + 1);

  typedef logic [c_ptr_w-1:0] ptr_t;

  logic [Width-1:0]   mem_q [Depth];
  ptr_t               wr_ptr_q, rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic               w_empty, w_push, w_pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (count_q == '0);
  assign full_o  = (count_q == c_cnt_w'(Depth));
  assign w_pop   = pop_i & ~w_empty;
  assign w_push  = push_i & (~full_o | w_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gemm_c_tile_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gemm_c_tile_drain: buffers GeMM C tiles and streams them as narrow beats to
// the C write port, with overflow flag and job-drained pulse. Rev 1.0
// ---------------------------------------------------------------------------
module gemm_c_tile_drain
  import gemm_pkg::*;
#(
  parameter  int unsigned RowPar       = 4,
  parameter  int unsigned ColPar       = 16,
  parameter  int unsigned OutDataWidth = 32,
  parameter  int unsigned AddrWidth    = 16,
  parameter  int unsigned BeatWidth    = 128,
  parameter  int unsigned Depth        = 2,
  localparam int unsigned TileWidth    = tile_width(RowPar, ColPar, OutDataWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 tile_we_i,
  input  logic [AddrWidth-1:0] tile_addr_i,
  input  logic [TileWidth-1:0] tile_data_i,
  output logic                 tile_ready_o,
  input  logic                 job_done_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic [BeatWidth-1:0] out_data_o,
  output logic                 overflow_o,
  output logic                 drain_done_o
);

  localparam int unsigned c_beats   = beats_per_tile(TileWidth, BeatWidth);
  localparam int unsigned c_idx_w   = idx_width(c_beats);
  localparam int unsigned c_cnt_w   = $clog2(Depth + 1);
  localparam int unsigned c_entry_w = AddrWidth + TileWidth;
  localparam int unsigned c_sel_w   = idx_width(TileWidth);
  localparam int unsigned c_prod_w  = AddrWidth + c_idx_w + 1;

  if ((TileWidth % BeatWidth) != 0) begin : g_bad_beat_width
    $fatal(1, "gemm_c_tile_drain: TileWidth must be a multiple of BeatWidth");
  end
  if (Depth < 1) begin : g_bad_depth
    $fatal(1, "gemm_c_tile_drain: Depth must be at least 1");
  end

  drain_state_e       state_q;
  done_state_e        done_q;
  logic [c_idx_w-1:0] beat_q;
  logic               overflow_q, drain_done_q;

  logic [c_entry_w-1:0] w_head;
  logic [AddrWidth-1:0] w_head_addr;
  logic [TileWidth-1:0] w_head_data;
  logic                 w_fifo_full;
  logic [c_cnt_w-1:0]   w_fifo_count, fifo_count_d;
  logic                 w_hs, w_last_beat, w_pop, w_push, w_drop;
  logic [c_sel_w-1:0]   w_sel;
  logic [c_prod_w-1:0]  w_addr_full;

  assign w_hs        = out_valid_o & out_ready_i;
  assign w_last_beat = (beat_q == c_idx_w'(c_beats - 1));
  assign w_pop       = w_hs & w_last_beat;
  assign w_push      = tile_we_i & (~w_fifo_full | w_pop);
  assign w_drop      = tile_we_i & ~w_push;
  assign fifo_count_d = w_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

  gemm_tile_fifo #(
    .Width (c_entry_w),
    .Depth (Depth)
  ) u_tile_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  ({tile_addr_i, tile_data_i}),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_fifo_full),
    .count_o (w_fifo_count)
  );

  assign w_head_addr = w_head[TileWidth +: AddrWidth];
  assign w_head_data = w_head[TileWidth-1:0];
  assign w_sel       = c_sel_w'(beat_q) * c_sel_w'(BeatWidth);
  // Product is kept wide enough for any tile index; only the low AddrWidth bits leave the block.
  assign w_addr_full = c_prod_w'(w_head_addr) * c_prod_w'(c_beats) + c_prod_w'(beat_q);

  assign out_valid_o  = (state_q == DrainStream);
  assign out_addr_o   = out_valid_o ? w_addr_full[AddrWidth-1:0] : '0;
  assign out_data_o   = out_valid_o ? w_head_data[w_sel +: BeatWidth] : '0;
  assign tile_ready_o = ~w_fifo_full;
  assign overflow_o   = overflow_q;
  assign drain_done_o = drain_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= DrainIdle;
      beat_q       <= '0;
      overflow_q   <= 1'b0;
      done_q       <= DoneNone;
      drain_done_q <= 1'b0;
    end else begin
      state_q <= (fifo_count_d != '0) ? DrainStream : DrainIdle;
      if (w_hs) begin
        beat_q <= w_last_beat ? '0 : beat_q + 1'b1;
      end
      if (w_drop) begin
        overflow_q <= 1'b1;
      end else if (start_i) begin
        overflow_q <= 1'b0;
      end
      // A tile pushed alongside job_done_i keeps the job pending until it drains.
      drain_done_q <= 1'b0;
      if (start_i) begin
        done_q <= DoneNone;
      end else if ((done_q == DonePending) || job_done_i) begin
        if (fifo_count_d == '0) begin
          drain_done_q <= 1'b1;
          done_q       <= DoneNone;
        end else begin
          done_q <= DonePending;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_c_tile_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gemm_c_tile_drain: directed, table-driven bench for gemm_c_tile_drain. Rev 1.0
// ---------------------------------------------------------------------------
module tb_gemm_c_tile_drain;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          tile_we_i = 1'b0;
  logic [15:0]   tile_addr_i = '0;
  logic [2047:0] tile_data_i = '0;
  logic          tile_ready_o;
  logic          job_done_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [15:0]   out_addr_o;
  logic [127:0]  out_data_o;
  logic          overflow_o;
  logic          drain_done_o;

  always #5 clk_i = ~clk_i;

  gemm_c_tile_drain dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .tile_we_i    (tile_we_i),
    .tile_addr_i  (tile_addr_i),
    .tile_data_i  (tile_data_i),
    .tile_ready_o (tile_ready_o),
    .job_done_i   (job_done_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_addr_o   (out_addr_o),
    .out_data_o   (out_data_o),
    .overflow_o   (overflow_o),
    .drain_done_o (drain_done_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    int          base;
  } tile_t;

  typedef struct {
    logic [15:0]  addr;
    int           base;
    int           mode;
    logic [15:0]  exp_addr0;
    logic [127:0] exp_d0;
  } vec_t;

  tile_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element k of a tile (row-major C[i][j], k = i*16+j) holds base+k.
  function automatic logic [2047:0] make_tile(input int base);
    logic [2047:0] t;
    for (int k = 0; k < 64; k++) t[k*32 +: 32] = 32'(base + k);
    return t;
  endfunction

  function automatic logic [127:0] beat_of(input int base, input int b);
    logic [127:0] r;
    for (int e = 0; e < 4; e++) r[e*32 +: 32] = 32'(base + 4*b + e);
    return r;
  endfunction

  task automatic push_tile(input logic [15:0] a, input int base, input logic done);
    tile_we_i   = 1'b1;
    tile_addr_i = a;
    tile_data_i = make_tile(base);
    job_done_i  = done;
    @(posedge clk_i); #1;
    tile_we_i  = 1'b0;
    job_done_i = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready toggles every cycle starting high.
  task automatic drain(input int mode, input int nbeats, input int inj_hs,
                       input logic [15:0] inj_addr, input int inj_base, output int cycles);
    int           hs = 0;
    int           bm = 0;
    int           cyc = 0;
    logic         stalled = 1'b0;
    logic [15:0]  s_addr = '0;
    logic [127:0] s_data = '0;
    logic [31:0]  full;
    out_ready_i = 1'b1;
    while (hs < nbeats && cyc < 400) begin
      @(negedge clk_i);
      if (stalled) begin
        chk("stall_valid", out_valid_o, 1'b1);
        chk("stall_addr", out_addr_o, s_addr);
        chk("stall_data", out_data_o, s_data);
      end
      stalled = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h expected no beat", out_addr_o);
        end else begin
          full = 32'(exp_q[0].addr) * 32'd16 + 32'(bm);
          chk("beat_addr", out_addr_o, full[15:0]);
          chk("beat_data", out_data_o, beat_of(exp_q[0].base, bm));
        end
        if (hs == inj_hs) begin
          chk("full_at_inject", tile_ready_o, 1'b0);
          tile_we_i   = 1'b1;
          tile_addr_i = inj_addr;
          tile_data_i = make_tile(inj_base);
          exp_q.push_back('{inj_addr, inj_base});
        end
        hs++;
        bm++;
        if (bm == 16) begin
          bm = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end else if (out_valid_o) begin
        stalled = 1'b1;
        s_addr  = out_addr_o;
        s_data  = out_data_o;
      end
      @(posedge clk_i); #1;
      tile_we_i = 1'b0;
      cyc++;
      if (mode == 1) out_ready_i = ~out_ready_i;
    end
    if (hs < nbeats) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", hs, nbeats);
    end
    out_ready_i = 1'b0;
    cycles = cyc;
  endtask

  initial begin
    vec_t vecs[4];
    int   cyc;

    vecs[0] = '{16'd3,    0,    0, 16'd48,    {32'd3,    32'd2,    32'd1,    32'd0}};
    vecs[1] = '{16'd4095, 100,  1, 16'd65520, {32'd103,  32'd102,  32'd101,  32'd100}};
    vecs[2] = '{16'h1001, 7,    1, 16'd16,    {32'd10,   32'd9,    32'd8,    32'd7}};
    vecs[3] = '{16'd0,    1000, 0, 16'd0,     {32'd1003, 32'd1002, 32'd1001, 32'd1000}};

    #12;
    chk("rst_tile_ready", tile_ready_o, 1'b1);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_addr", out_addr_o, 16'd0);
    chk("rst_data", out_data_o, 128'd0);
    chk("rst_overflow", overflow_o, 1'b0);
    chk("rst_drain_done", drain_done_o, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    job_done_i = 1'b1;
    @(posedge clk_i); #1;
    job_done_i = 1'b0;
    chk("done_empty_pulse", drain_done_o, 1'b1);
    @(posedge clk_i); #1;
    chk("done_empty_clear", drain_done_o, 1'b0);

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{vecs[i].addr, vecs[i].base});
      push_tile(vecs[i].addr, vecs[i].base, 1'b1);
      chk("latency_valid", out_valid_o, 1'b1);
      chk("beat0_addr", out_addr_o, vecs[i].exp_addr0);
      chk("beat0_data", out_data_o, vecs[i].exp_d0);
      chk("done_early", drain_done_o, 1'b0);
      drain(vecs[i].mode, 16, -1, 16'd0, 0, cyc);
      chk("vec_drain_done", drain_done_o, 1'b1);
      chk("vec_valid_low", out_valid_o, 1'b0);
      if (vecs[i].mode == 0) chk("vec_cycles", 128'(cyc), 128'd16);
      @(posedge clk_i); #1;
      chk("vec_done_pulse", drain_done_o, 1'b0);
    end

    exp_q.push_back('{16'd10, 200});
    exp_q.push_back('{16'd11, 300});
    push_tile(16'd10, 200, 1'b0);
    chk("ovf_ready_after1", tile_ready_o, 1'b1);
    push_tile(16'd11, 300, 1'b0);
    chk("ovf_ready_after2", tile_ready_o, 1'b0);
    chk("ovf_before_drop", overflow_o, 1'b0);
    push_tile(16'd12, 400, 1'b0);
    chk("ovf_set", overflow_o, 1'b1);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("ovf_cleared", overflow_o, 1'b0);
    drain(0, 32, -1, 16'd0, 0, cyc);
    chk("ovf_cycles", 128'(cyc), 128'd32);
    chk("ovf_third_lost", out_valid_o, 1'b0);

    exp_q.push_back('{16'd20, 500});
    exp_q.push_back('{16'd21, 600});
    push_tile(16'd20, 500, 1'b0);
    push_tile(16'd21, 600, 1'b0);
    drain(0, 48, 15, 16'd22, 700, cyc);
    chk("pop_push_no_ovf", overflow_o, 1'b0);
    chk("pop_push_cycles", 128'(cyc), 128'd48);
    chk("pop_push_empty", out_valid_o, 1'b0);

    push_tile(16'd5, 800, 1'b0);
    out_ready_i = 1'b1;
    repeat (7) begin
      @(posedge clk_i); #1;
    end
    chk("mid_beat7_addr", out_addr_o, 16'd87);
    chk("mid_beat7_data", out_data_o, beat_of(800, 7));
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 1'b0);
    chk("arst_addr", out_addr_o, 16'd0);
    chk("arst_data", out_data_o, 128'd0);
    chk("arst_tile_ready", tile_ready_o, 1'b1);
    chk("arst_overflow", overflow_o, 1'b0);
    chk("arst_drain_done", drain_done_o, 1'b0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    exp_q.push_back('{16'd6, 900});
    push_tile(16'd6, 900, 1'b0);
    chk("post_rst_addr0", out_addr_o, 16'd96);
    drain(1, 16, -1, 16'd0, 0, cyc);
    chk("post_rst_empty", out_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
